// File: rtl/freq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_pkg: shared widths, display limit and FSM encoding for the       |
// | frequency counter's binary-to-BCD conversion path.                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package freq_pkg;

    localparam int BIN_WIDTH_DEF = 32;
    localparam int DIGITS_DEF    = 8;

    // Largest value an 8-digit display can show (99_999_999).
    localparam logic [31:0] MAX_DISPLAY = 32'h05F5E0FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 10^digits - 1, used when DIGITS is overridden away from the default.
    function automatic logic [63:0] max_display_for(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_adj: double-dabble correction cell, adds 3 to a BCD digit    |
// | that is 5 or more so the following left shift carries correctly.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/freq_bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_bcd_converter: sequential shift-and-add-3 binary-to-BCD converter |
// | with held outputs and saturation to all nines on overflow.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module freq_bcd_converter
    import freq_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_WIDTH_DEF,
    parameter int DIGITS    = DIGITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          CNT_W     = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [63:0] MAX_LIMIT = max_display_for(DIGITS);

    state_t               state;
    state_t               state_next;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0]     scratch;
    logic [BCD_W-1:0]     adjusted;
    logic [CNT_W-1:0]     iter_cnt;
    logic                 ovf_flag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (adjusted[4*g +: 4])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (iter_cnt == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            iter_cnt  <= '0;
            ovf_flag  <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        scratch   <= '0;
                        iter_cnt  <= CNT_W'(BIN_WIDTH - 1);
                        ovf_flag  <= (64'(bin) > MAX_LIMIT);
                    end
                end
                ST_SHIFT: begin
                    // The truncating cast drops the carry out of the top digit.
                    scratch   <= BCD_W'({adjusted, shift_reg[BIN_WIDTH-1]});
                    shift_reg <= shift_reg << 1;
                    if (iter_cnt != '0) begin
                        iter_cnt <= iter_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bcd      <= ovf_flag ? {DIGITS{4'h9}} : scratch;
                    overflow <= ovf_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
